axi_sram_arb2: RTL

Two-requester AXI4 arbiter that shares one `AxiSram` slave (64-bit data, 4-bit IDs) between two AXI masters, e.g. the TLX master domain and a local DMA/debug master. Read and write directions are arbitrated independently, each by a small FSM. Each master's ID is extended by one MSB carrying the requester index. B and R responses are routed back by that MSB, so no response bookkeeping is needed.

---
 rtl/axi_sram_arb2.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_arb2.sv
// axi_sram_arb2: two-master AXI4 arbiter in front of one AxiSram slave, independent round-robin read/write FSMs.
// Define AXI_SRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins ties).
module axi_sram_arb2 #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ID_WIDTH-1:0]     s0_awid,
  input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic [7:0]              s0_awlen,
  input  logic [2:0]              s0_awsize,
  input  logic [1:0]              s0_awburst,
  input  logic                    s0_awvalid,
  output logic                    s0_awready,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic                    s0_wlast,
  input  logic                    s0_wvalid,
  output logic                    s0_wready,
  output logic [ID_WIDTH-1:0]     s0_bid,
  output logic [1:0]              s0_bresp,
  output logic                    s0_bvalid,
  input  logic                    s0_bready,
  input  logic [ID_WIDTH-1:0]     s0_arid,
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic [7:0]              s0_arlen,
  input  logic [2:0]              s0_arsize,
  input  logic [1:0]              s0_arburst,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  output logic [ID_WIDTH-1:0]     s0_rid,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic [1:0]              s0_rresp,
  output logic                    s0_rlast,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  input  logic [ID_WIDTH-1:0]     s1_awid,
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [7:0]              s1_awlen,
  input  logic [2:0]              s1_awsize,
  input  logic [1:0]              s1_awburst,
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                    s1_wlast,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  output logic [ID_WIDTH-1:0]     s1_bid,
  output logic [1:0]              s1_bresp,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  input  logic [ID_WIDTH-1:0]     s1_arid,
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic [7:0]              s1_arlen,
  input  logic [2:0]              s1_arsize,
  input  logic [1:0]              s1_arburst,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  output logic [ID_WIDTH-1:0]     s1_rid,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic [1:0]              s1_rresp,
  output logic                    s1_rlast,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  output logic [ID_WIDTH:0]       m_awid,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [ID_WIDTH:0]       m_bid,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ID_WIDTH:0]       m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [ID_WIDTH:0]       m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_t;
  typedef enum logic {R_IDLE, R_ADDR} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic wgnt, wgnt_next, rgnt, rgnt_next;
  logic w_pick, r_pick, aw_hs, ar_hs;
  assign aw_hs = m_awvalid & m_awready;
  assign ar_hs = m_arvalid & m_arready;
`ifdef AXI_SRAM_ARB_FIXED_PRIO_EN
  assign w_pick = ~s0_awvalid;
  assign r_pick = ~s0_arvalid;
`else
  logic last_w, last_r;
  assign w_pick = (s0_awvalid & s1_awvalid) ? ~last_w : s1_awvalid;
  assign r_pick = (s0_arvalid & s1_arvalid) ? ~last_r : s1_arvalid;
  // fairness history moves only once the address is actually accepted
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      last_w <= 1'b1;
      last_r <= 1'b1;
    end else begin
      if (aw_hs) last_w <= wgnt;
      if (ar_hs) last_r <= rgnt;
    end
`endif
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      wgnt    <= 1'b0;
      rgnt    <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      wgnt    <= wgnt_next;
      rgnt    <= rgnt_next;
    end
  always_comb begin
    w_next    = w_state;
    wgnt_next = wgnt;
    case (w_state)
      W_IDLE: if (s0_awvalid | s1_awvalid) begin
        w_next    = W_ADDR;
        wgnt_next = w_pick;
      end
      W_ADDR: if (aw_hs) w_next = W_DATA;
      W_DATA: if (m_wvalid & m_wready & m_wlast) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end
  always_comb begin
    r_next    = r_state;
    rgnt_next = rgnt;
    if (r_state == R_IDLE && (s0_arvalid | s1_arvalid)) begin
      r_next    = R_ADDR;
      rgnt_next = r_pick;
    end else if (r_state == R_ADDR && ar_hs) r_next = R_IDLE;
  end
  assign m_awvalid  = (w_state == W_ADDR) & (wgnt ? s1_awvalid : s0_awvalid);
  assign m_awid     = {wgnt, wgnt ? s1_awid : s0_awid};
  assign m_awaddr   = wgnt ? s1_awaddr : s0_awaddr;
  assign m_awlen    = wgnt ? s1_awlen : s0_awlen;
  assign m_awsize   = wgnt ? s1_awsize : s0_awsize;
  assign m_awburst  = wgnt ? s1_awburst : s0_awburst;
  assign s0_awready = (w_state == W_ADDR) & ~wgnt & m_awready;
  assign s1_awready = (w_state == W_ADDR) & wgnt & m_awready;
  assign m_wvalid   = (w_state == W_DATA) & (wgnt ? s1_wvalid : s0_wvalid);
  assign m_wdata    = wgnt ? s1_wdata : s0_wdata;
  assign m_wstrb    = wgnt ? s1_wstrb : s0_wstrb;
  assign m_wlast    = wgnt ? s1_wlast : s0_wlast;
  assign s0_wready  = (w_state == W_DATA) & ~wgnt & m_wready;
  assign s1_wready  = (w_state == W_DATA) & wgnt & m_wready;
  assign m_arvalid  = (r_state == R_ADDR) & (rgnt ? s1_arvalid : s0_arvalid);
  assign m_arid     = {rgnt, rgnt ? s1_arid : s0_arid};
  assign m_araddr   = rgnt ? s1_araddr : s0_araddr;
  assign m_arlen    = rgnt ? s1_arlen : s0_arlen;
  assign m_arsize   = rgnt ? s1_arsize : s0_arsize;
  assign m_arburst  = rgnt ? s1_arburst : s0_arburst;
  assign s0_arready = (r_state == R_ADDR) & ~rgnt & m_arready;
  assign s1_arready = (r_state == R_ADDR) & rgnt & m_arready;
  // responses are steered purely by the requester bit folded into the ID
  assign s0_bvalid  = m_bvalid & ~m_bid[ID_WIDTH];
  assign s1_bvalid  = m_bvalid & m_bid[ID_WIDTH];
  assign s0_bid     = m_bid[ID_WIDTH-1:0];
  assign s1_bid     = m_bid[ID_WIDTH-1:0];
  assign s0_bresp   = m_bresp;
  assign s1_bresp   = m_bresp;
  assign m_bready   = m_bid[ID_WIDTH] ? s1_bready : s0_bready;
  assign s0_rvalid  = m_rvalid & ~m_rid[ID_WIDTH];
  assign s1_rvalid  = m_rvalid & m_rid[ID_WIDTH];
  assign s0_rid     = m_rid[ID_WIDTH-1:0];
  assign s1_rid     = m_rid[ID_WIDTH-1:0];
  assign s0_rdata   = m_rdata;
  assign s1_rdata   = m_rdata;
  assign s0_rresp   = m_rresp;
  assign s1_rresp   = m_rresp;
  assign s0_rlast   = m_rlast;
  assign s1_rlast   = m_rlast;
  assign m_rready   = m_rid[ID_WIDTH] ? s1_rready : s0_rready;
endmodule
